// File: rtl/trace_pkg.sv
// Shared types for write-back trace checking: FSM states, fail causes, trace entry.
// Latency: n/a (types and one pure function only).
// Backpressure: n/a.
package trace_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PASS = 2'd2,
      FAIL = 2'd3
   } state_t;

   localparam logic [1:0] CAUSE_NONE     = 2'd0;
   localparam logic [1:0] CAUSE_MISMATCH = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
   localparam logic [1:0] CAUSE_OVERFLOW = 2'd3;

   // One retired instruction as seen on the write-back debug port.
   // rd holds the destination register number.
   typedef struct packed {
      logic [31:0] pc;
      logic        ena;
      logic [4:0]  rd;
      logic [31:0] value;
   } trace_entry_t;

   // x0 is hard-wired to zero, so a write to it is architecturally a no-op.
   function automatic logic eff_wr(input trace_entry_t e);
      return e.ena && (e.rd != 5'd0);
   endfunction

endpackage

// File: rtl/trace_cmp.sv
// Combinational match of a retired instruction against its golden entry.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports:
//   dut_i   - entry captured from the core
//   gold_i  - entry read from the golden trace
//   match_o - 1 when both entries describe the same architectural effect
module trace_cmp
   import trace_pkg::*;
(
   input  trace_entry_t dut_i,
   input  trace_entry_t gold_i,
   output logic         match_o
);

   logic dut_we;
   logic gold_we;

   always_comb begin
      dut_we  = eff_wr(dut_i);
      gold_we = eff_wr(gold_i);
      // Register and value only matter when the write actually lands.
      match_o = (dut_i.pc == gold_i.pc) &&
                (dut_we == gold_we) &&
                (!dut_we || ((dut_i.rd == gold_i.rd) && (dut_i.value == gold_i.value)));
   end

endmodule

// File: rtl/wb_trace_checker.sv
// Checks the core's write-back debug stream against a golden trace in sync-read memory.
// Latency: retirement in cycle t -> verdict / inst_cnt visible in t+2; one retirement per cycle sustained.
// Backpressure: none; the core is never stalled, retirements outside RUN or in a verdict cycle are dropped.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   start                    - arm the checker (ignored while busy)
//   debug_wb_*               - retirement stream from the core
//   gold_addr / gold_*       - golden memory index out, entry back one cycle later
//   busy, pass, fail         - FSM status
//   fail_cause, err_idx,
//   err_pc                   - failure report, held until start or rst
//   inst_cnt                 - matched retirements since start
module wb_trace_checker
   import trace_pkg::*;
#(
   parameter int IDX_W   = 12,
   parameter int TIMEOUT = 65536
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             debug_wb_have_inst,
   input  logic [31:0]      debug_wb_pc,
   input  logic             debug_wb_ena,
   input  logic [4:0]       debug_wb_reg,
   input  logic [31:0]      debug_wb_value,
   output logic [IDX_W-1:0] gold_addr,
   input  logic [31:0]      gold_pc,
   input  logic             gold_ena,
   input  logic [4:0]       gold_reg,
   input  logic [31:0]      gold_value,
   input  logic             gold_last,
   output logic             busy,
   output logic             pass,
   output logic             fail,
   output logic [1:0]       fail_cause,
   output logic [IDX_W-1:0] err_idx,
   output logic [31:0]      err_pc,
   output logic [31:0]      inst_cnt
);

   localparam int               TO_W    = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IDX_MAX = '1;

   state_t             state_q,   state_d;
   logic [IDX_W-1:0]   idx_q,     idx_d;
   logic [31:0]        cnt_q,     cnt_d;
   logic [TO_W-1:0]    to_q,      to_d;
   logic               cap_v_q,   cap_v_d;
   trace_entry_t       cap_q,     cap_d;
   logic [1:0]         cause_q,   cause_d;
   logic [IDX_W-1:0]   err_idx_q, err_idx_d;
   logic [31:0]        err_pc_q,  err_pc_d;

   trace_entry_t       dbg_entry;
   trace_entry_t       gold_entry;
   logic               match;
   logic               verdict;
   logic [IDX_W-1:0]   cmp_idx;

   assign dbg_entry  = '{pc: debug_wb_pc, ena: debug_wb_ena, rd: debug_wb_reg, value: debug_wb_value};
   assign gold_entry = '{pc: gold_pc, ena: gold_ena, rd: gold_reg, value: gold_value};

   // idx advanced when the entry under compare was captured, so its index is one behind.
   assign cmp_idx = idx_q - IDX_W'(1);

   trace_cmp u_cmp (
      .dut_i   (cap_q),
      .gold_i  (gold_entry),
      .match_o (match)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      to_d      = to_q;
      cap_v_d   = cap_v_q;
      cap_d     = cap_q;
      cause_d   = cause_q;
      err_idx_d = err_idx_q;
      err_pc_d  = err_pc_q;
      verdict   = 1'b0;

      case (state_q)
         RUN: begin
            cap_v_d = 1'b0;
            if (cap_v_q) begin
               if (match) begin
                  cnt_d = cnt_q + 32'd1;
                  if (gold_last) begin
                     state_d = PASS;
                     verdict = 1'b1;
                  end else if (cmp_idx == IDX_MAX) begin
                     state_d   = FAIL;
                     cause_d   = CAUSE_OVERFLOW;
                     err_idx_d = cmp_idx;
                     err_pc_d  = cap_q.pc;
                     verdict   = 1'b1;
                  end
               end else begin
                  state_d   = FAIL;
                  cause_d   = CAUSE_MISMATCH;
                  err_idx_d = cmp_idx;
                  err_pc_d  = cap_q.pc;
                  verdict   = 1'b1;
               end
            end

            // A compare verdict wins the cycle: a concurrent retirement or timeout is dropped.
            if (!verdict) begin
               if (debug_wb_have_inst) begin
                  cap_d   = dbg_entry;
                  cap_v_d = 1'b1;
                  idx_d   = idx_q + IDX_W'(1);
                  to_d    = '0;
               end else if (to_q == TO_LAST) begin
                  state_d   = FAIL;
                  cause_d   = CAUSE_TIMEOUT;
                  err_idx_d = idx_q;
                  err_pc_d  = 32'd0;
               end else begin
                  to_d = to_q + TO_W'(1);
               end
            end
         end

         default: begin
            if (start) begin
               state_d   = RUN;
               idx_d     = '0;
               cnt_d     = 32'd0;
               to_d      = '0;
               cap_v_d   = 1'b0;
               cause_d   = CAUSE_NONE;
               err_idx_d = '0;
               err_pc_d  = 32'd0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         cnt_q     <= 32'd0;
         to_q      <= '0;
         cap_v_q   <= 1'b0;
         cap_q     <= '0;
         cause_q   <= CAUSE_NONE;
         err_idx_q <= '0;
         err_pc_q  <= 32'd0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         to_q      <= to_d;
         cap_v_q   <= cap_v_d;
         cap_q     <= cap_d;
         cause_q   <= cause_d;
         err_idx_q <= err_idx_d;
         err_pc_q  <= err_pc_d;
      end
   end

   assign gold_addr  = idx_q;
   assign busy       = (state_q == RUN);
   assign pass       = (state_q == PASS);
   assign fail       = (state_q == FAIL);
   assign fail_cause = cause_q;
   assign err_idx    = err_idx_q;
   assign err_pc     = err_pc_q;
   assign inst_cnt   = cnt_q;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed bench for wb_trace_checker with a due-cycle scoreboard.
// Instance A: IDX_W=12, TIMEOUT=16. Instance B: IDX_W=2, TIMEOUT=1 (overflow and
// verdict-vs-timeout collisions). Both share the retirement stream and reset.
module tb_wb_trace_checker;
   import trace_pkg::*;

   localparam longint NC = -1;   // field not checked

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        start_a = 1'b0, start_b = 1'b0;
   logic        have = 1'b0;
   logic [31:0] pc = '0, val = '0;
   logic        ena = 1'b0;
   logic [4:0]  rd = '0;

   // ---------------- instance A ----------------
   logic [11:0]  ga_a;
   trace_entry_t mem_a [16];
   logic         last_a [16];
   trace_entry_t rd_a;
   logic         rdl_a;
   logic         busy_a, pass_a, fail_a;
   logic [1:0]   cause_a;
   logic [11:0]  eidx_a;
   logic [31:0]  epc_a, cnt_a;

   always @(posedge clk) begin
      rd_a  <= mem_a[ga_a[3:0]];
      rdl_a <= last_a[ga_a[3:0]];
   end

   wb_trace_checker #(.IDX_W(12), .TIMEOUT(16)) dut_a (
      .clk(clk), .rst(rst), .start(start_a),
      .debug_wb_have_inst(have), .debug_wb_pc(pc), .debug_wb_ena(ena),
      .debug_wb_reg(rd), .debug_wb_value(val),
      .gold_addr(ga_a), .gold_pc(rd_a.pc), .gold_ena(rd_a.ena), .gold_reg(rd_a.rd),
      .gold_value(rd_a.value), .gold_last(rdl_a),
      .busy(busy_a), .pass(pass_a), .fail(fail_a), .fail_cause(cause_a),
      .err_idx(eidx_a), .err_pc(epc_a), .inst_cnt(cnt_a)
   );

   // ---------------- instance B ----------------
   logic [1:0]   ga_b;
   trace_entry_t mem_b [4];
   logic         last_b [4];
   trace_entry_t rd_b;
   logic         rdl_b;
   logic         busy_b, pass_b, fail_b;
   logic [1:0]   cause_b;
   logic [1:0]   eidx_b;
   logic [31:0]  epc_b, cnt_b;

   always @(posedge clk) begin
      rd_b  <= mem_b[ga_b];
      rdl_b <= last_b[ga_b];
   end

   wb_trace_checker #(.IDX_W(2), .TIMEOUT(1)) dut_b (
      .clk(clk), .rst(rst), .start(start_b),
      .debug_wb_have_inst(have), .debug_wb_pc(pc), .debug_wb_ena(ena),
      .debug_wb_reg(rd), .debug_wb_value(val),
      .gold_addr(ga_b), .gold_pc(rd_b.pc), .gold_ena(rd_b.ena), .gold_reg(rd_b.rd),
      .gold_value(rd_b.value), .gold_last(rdl_b),
      .busy(busy_b), .pass(pass_b), .fail(fail_b), .fail_cause(cause_b),
      .err_idx(eidx_b), .err_pc(epc_b), .inst_cnt(cnt_b)
   );

   // ---------------- scoreboard ----------------
   typedef struct {
      string  tag;
      int     due;
      bit     b;
      longint busy, pas, fal, cause, eidx, epc, cnt, ga;
   } exp_t;

   exp_t sb [$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void push(input string tag, input bit b, input int dly,
                                input longint busy, input longint pas, input longint fal,
                                input longint cause, input longint eidx, input longint epc,
                                input longint cnt, input longint ga);
      exp_t e;
      e.tag = tag; e.due = cyc + dly; e.b = b;
      e.busy = busy; e.pas = pas; e.fal = fal; e.cause = cause;
      e.eidx = eidx; e.epc = epc; e.cnt = cnt; e.ga = ga;
      sb.push_back(e);
   endfunction

   task automatic chk(input string tag, input string fld, input logic [63:0] obs, input longint ex);
      if (ex >= 0) begin
         n_cmp++;
         assert (obs === 64'(ex))
         else begin
            n_bad++;
            $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tag, fld, obs, ex);
         end
      end
   endtask

   task automatic check_one(input exp_t e);
      chk(e.tag, "busy",       e.b ? 64'(busy_b)  : 64'(busy_a),  e.busy);
      chk(e.tag, "pass",       e.b ? 64'(pass_b)  : 64'(pass_a),  e.pas);
      chk(e.tag, "fail",       e.b ? 64'(fail_b)  : 64'(fail_a),  e.fal);
      chk(e.tag, "fail_cause", e.b ? 64'(cause_b) : 64'(cause_a), e.cause);
      chk(e.tag, "err_idx",    e.b ? 64'(eidx_b)  : 64'(eidx_a),  e.eidx);
      chk(e.tag, "err_pc",     e.b ? 64'(epc_b)   : 64'(epc_a),   e.epc);
      chk(e.tag, "inst_cnt",   e.b ? 64'(cnt_b)   : 64'(cnt_a),   e.cnt);
      chk(e.tag, "gold_addr",  e.b ? 64'(ga_b)    : 64'(ga_a),    e.ga);
   endtask

   always @(negedge clk) begin
      int i;
      i = 0;
      while (i < sb.size()) begin
         if (sb[i].due == cyc) begin
            check_one(sb[i]);
            sb.delete(i);
         end else begin
            i++;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] p, input logic e, input logic [4:0] r, input logic [31:0] v);
      have = 1'b1; pc = p; ena = e; rd = r; val = v;
   endtask

   task automatic idle();
      have = 1'b0; pc = '0; ena = 1'b0; rd = '0; val = '0;
   endtask

   function automatic void set_a(input int i, input logic [31:0] p, input logic e,
                                 input logic [4:0] r, input logic [31:0] v, input logic l);
      mem_a[i]  = '{pc: p, ena: e, rd: r, value: v};
      last_a[i] = l;
   endfunction

   function automatic void set_b(input int i, input logic [31:0] p, input logic e,
                                 input logic [4:0] r, input logic [31:0] v, input logic l);
      mem_b[i]  = '{pc: p, ena: e, rd: r, value: v};
      last_b[i] = l;
   endfunction

   function automatic void load_pass_a();
      set_a(0, 32'h100, 1'b1, 5'd1, 32'h11, 1'b0);
      set_a(1, 32'h104, 1'b0, 5'd0, 32'h00, 1'b0);
      set_a(2, 32'h108, 1'b1, 5'd2, 32'h22, 1'b1);
   endfunction

   task automatic start_pulse(input bit b);
      if (b) start_b = 1'b1; else start_a = 1'b1;
      tick();
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   // Called in the first RUN cycle after a start on instance A.
   task automatic run_pass_a(input string p);
      drive(32'h100, 1'b1, 5'd1, 32'h11);
      push({p, "_cnt1"}, 1'b0, 2, 1, 0, 0, 0, NC, NC, 1, NC);
      tick();
      drive(32'h104, 1'b0, 5'd0, 32'h0);
      push({p, "_cnt2"}, 1'b0, 2, 1, 0, 0, 0, NC, NC, 2, NC);
      tick();
      drive(32'h108, 1'b1, 5'd2, 32'h22);
      push({p, "_pass"}, 1'b0, 2, 0, 1, 0, 0, 0, 0, 3, 3);
      tick();
      idle();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      for (int i = 0; i < 16; i++) set_a(i, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++)  set_b(i, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);

      // Reset state
      rst = 1'b1;
      tick();
      tick();
      push("rst_a", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      push("rst_b", 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      tick();

      // T1: three back-to-back matches, last on entry 2; later retirements ignored
      load_pass_a();
      start_pulse(1'b0);
      push("t1_start", 1'b0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      run_pass_a("t1");
      drive(32'h10C, 1'b1, 5'd3, 32'h33);   // lands in the verdict cycle
      tick();
      push("t1_hold", 1'b0, 1, 0, 1, 0, 0, 0, 0, 3, 3);
      tick();                               // in PASS
      idle();
      tick();

      // T2: value mismatch on entry 1
      set_a(0, 32'h200, 1'b1, 5'd1, 32'h1, 1'b0);
      set_a(1, 32'h204, 1'b1, 5'd2, 32'h6, 1'b0);
      set_a(2, 32'h208, 1'b1, 5'd3, 32'h9, 1'b1);
      start_pulse(1'b0);
      push("t2_start", 1'b0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      drive(32'h200, 1'b1, 5'd1, 32'h1);
      push("t2_cnt1", 1'b0, 2, 1, 0, 0, 0, NC, NC, 1, NC);
      tick();
      drive(32'h204, 1'b1, 5'd2, 32'h5);
      push("t2_mis", 1'b0, 2, 0, 0, 1, 1, 1, 32'h204, 1, 2);
      tick();
      drive(32'h208, 1'b1, 5'd3, 32'h9);   // verdict cycle, discarded
      tick();
      drive(32'h208, 1'b1, 5'd3, 32'h9);   // in FAIL, ignored
      push("t2_hold", 1'b0, 1, 0, 0, 1, 1, 1, 32'h204, 1, 2);
      tick();
      idle();
      tick();

      // T3: x0 rule; restart from FAIL clears the report
      set_a(0, 32'h300, 1'b0, 5'd0, 32'h0, 1'b0);
      set_a(1, 32'h304, 1'b1, 5'd3, 32'h7, 1'b0);
      start_pulse(1'b0);
      push("t3_start", 1'b0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      drive(32'h300, 1'b1, 5'd0, 32'hDEAD_BEEF);
      push("t3_x0", 1'b0, 2, 1, 0, 0, 0, 0, 0, 1, NC);
      tick();
      drive(32'h304, 1'b0, 5'd3, 32'h7);
      push("t3_ena", 1'b0, 2, 0, 0, 1, 1, 1, 32'h304, 1, NC);
      tick();
      idle();
      tick();
      tick();

      // T4: timeout after 16 idle RUN cycles following one match
      set_a(0, 32'h400, 1'b1, 5'd4, 32'h44, 1'b0);
      start_pulse(1'b0);
      push("t4_start", 1'b0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      drive(32'h400, 1'b1, 5'd4, 32'h44);
      tick();
      idle();
      push("t4_pre", 1'b0, 15, 1, 0, 0, 0, 0, 0, 1, 1);
      push("t4_to",  1'b0, 16, 0, 0, 1, 2, 1, 0, 1, 1);
      repeat (18) tick();

      // T5: rst mid-stream, then restart (retirement in the start cycle ignored)
      load_pass_a();
      start_pulse(1'b0);
      drive(32'h100, 1'b1, 5'd1, 32'h11);
      push("t5_cnt1", 1'b0, 2, 1, 0, 0, 0, NC, NC, 1, NC);
      tick();
      drive(32'h104, 1'b0, 5'd0, 32'h0);
      tick();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      push("t5_rst", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      drive(32'h100, 1'b1, 5'd1, 32'h11);
      start_pulse(1'b0);
      idle();
      push("t5_start", 1'b0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      run_pass_a("t5");
      tick();
      tick();

      // T6: IDX_W=2 overflow after 4 matches without last (coincides with timeout)
      for (int i = 0; i < 4; i++)
         set_b(i, 32'h500 + 32'(4 * i), 1'b1, 5'(i + 1), 32'(3 * i + 1), 1'b0);
      start_pulse(1'b1);
      push("t6_start", 1'b1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         drive(32'h500 + 32'(4 * i), 1'b1, 5'(i + 1), 32'(3 * i + 1));
         if (i == 2) push("t6_cnt3", 1'b1, 2, 1, 0, 0, 0, NC, NC, 3, NC);
         if (i == 3) push("t6_ovf",  1'b1, 2, 0, 0, 1, 3, 3, NC, NC, NC);
         tick();
      end
      idle();
      tick();
      tick();

      // T7: mismatch in the same cycle the timeout expires -> cause 1
      set_b(0, 32'h600, 1'b1, 5'd1, 32'h11, 1'b0);
      start_pulse(1'b1);
      push("t7_start", 1'b1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      drive(32'h600, 1'b1, 5'd1, 32'h12);
      push("t7_mis", 1'b1, 2, 0, 0, 1, 1, 0, 32'h600, 0, NC);
      tick();
      idle();
      tick();
      tick();

      // T8: plain timeout with TIMEOUT=1
      start_pulse(1'b1);
      push("t8_start", 1'b1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      push("t8_to",    1'b1, 1, 0, 0, 1, 2, 0, 0, 0, 0);
      repeat (3) tick();

      n_cmp++;
      assert (sb.size() == 0)
      else begin
         n_bad++;
         $error("FAIL sb_drain observed=%0d expected=0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wb_trace_checker.md
# wb_trace_checker

Self-checking trace consumer for the pipelined RV32I core. It sits beside the CPU and receives the write-back debug stream the core emits once per retired instruction (have_inst, pc, ena, reg, value). Each retired instruction is compared against a golden trace held in an external synchronous-read memory. The block reports PASS at the golden end marker, or FAIL with cause, index and offending PC.

## Interface
Parameters:
- IDX_W, 12: golden-trace index width (depth 2^IDX_W entries)
- TIMEOUT, 65536: consecutive RUN cycles with no retirement before FAIL

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  arm checker; honoured in IDLE, PASS, FAIL; ignored in RUN
- debug_wb_have_inst  in  1  one instruction retires this cycle
- debug_wb_pc  in  32  PC of the retiring instruction
- debug_wb_ena  in  1  RF write enable
- debug_wb_reg  in  5  destination register
- debug_wb_value  in  32  write-back value
- gold_addr  out  IDX_W  golden memory read index; equals the idx register
- gold_pc  in  32  golden PC (valid 1 cycle after gold_addr)
- gold_ena  in  1  golden write enable
- gold_reg  in  5  golden destination register
- gold_value  in  32  golden write-back value
- gold_last  in  1  entry is the final instruction
- busy  out  1  state == RUN
- pass  out  1  state == PASS
- fail  out  1  state == FAIL
- fail_cause  out  2  0 none, 1 mismatch, 2 timeout, 3 overflow
- err_idx  out  IDX_W  golden index of the failing entry
- err_pc  out  32  DUT PC of the failing entry (0 for timeout)
- inst_cnt  out  32  matched retirements since start

## Operation
- FSM states: IDLE, RUN, PASS, FAIL.
- Reset: state IDLE. All outputs are 0, including gold_addr, idx, inst_cnt, fail_cause, err_*, and the capture valid flag cap_v.
- IDLE/PASS/FAIL with start high: go to RUN. Clear idx, inst_cnt, timeout counter, cap_v, fail_cause and err_*.
- Retirements outside RUN are ignored, including any after PASS.
- Capture stage, RUN with have_inst=1:
  - Register pc, ena, reg and value.
  - Set cap_v.
  - Increment idx. gold_addr already presents the old idx, so the memory returns the matching entry next cycle.
- Compare stage, cap_v=1:
  - Effective enable is ena && reg!=0, computed for both the DUT and the golden entry.
  - Match requires: pc equal, and effective enables equal, and (if the effective enable is 1) reg and value equal.
  - A write to x0 never compares its value.
- Compare outcomes:
  - Match with gold_last=1: go to PASS.
  - Match on index 2^IDX_W-1 without last: FAIL, cause 3.
  - Mismatch: FAIL, cause 1, with err_idx and err_pc latched.
  - Other matches: increment inst_cnt.
- Timeout counter:
  - Increments on each RUN cycle with have_inst=0.
  - Clears on have_inst=1.
  - At TIMEOUT: FAIL, cause 2, err_idx=idx, err_pc=0.
- Priority within one cycle: compare result > timeout. A retirement arriving in the same cycle as a verdict is discarded.
- fail_cause, err_idx and err_pc hold until start or rst.

## Timing
- Retirement sampled in cycle t:
  - gold_addr=k during t.
  - Golden data and captured entry both valid in t+1.
  - Verdict, inst_cnt and state update at the end of t+1, so they are visible in t+2.
- Back-to-back retirements on every cycle are sustained with no stall. Capture and compare overlap fully.
- start in cycle t: busy=1 and gold_addr=0 in t+1. A retirement in cycle t itself is ignored.
- rst mid-RUN: IDLE next cycle. The in-flight compare is discarded.
- Timeout on TIMEOUT consecutive idle cycles: fail=1 one cycle after the last counted cycle.

## Structure
- Package trace_pkg:
  - state enum: IDLE, RUN, PASS, FAIL
  - fail-cause constants: CAUSE_NONE, CAUSE_MISMATCH, CAUSE_TIMEOUT, CAUSE_OVERFLOW
  - trace-entry struct: pc, ena, reg, value
- Sub-module trace_cmp: purely combinational match of two entries using the x0 rule. It is shared with future trace-diff tools.
- The top holds the FSM, capture register, idx, timeout and inst_cnt counters.

## Test plan
- Start; 3 back-to-back retirements matching golden entries 0–2, last on 2 -> pass=1 two cycles after the third, inst_cnt=3.
- Entry 1 value 0x0000_0005 vs golden 0x0000_0006 -> fail, fail_cause=1, err_idx=1, err_pc=DUT PC; later retirements ignored.
- DUT ena=1 reg=0 value=0xDEAD_BEEF vs golden ena=0 -> match; golden ena=1 reg=3 vs DUT ena=0 -> mismatch.
- TIMEOUT=16, no retirement for 16 cycles after start -> fail_cause=2, err_pc=0. A mismatch landing in the same cycle as the timeout reports cause 1.
- IDX_W=2, 4 matching entries without last -> fail_cause=3, err_idx=3.
- rst asserted mid-stream, then start -> gold_addr=0, inst_cnt=0, full trace passes.
